pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer_if.sv | 22 ++
 rtl/pll_lock_sequencer.sv | 121 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its environment.
// The sequencer drives PLL/core resets and status; the environment drives lock and restart.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost_stb;
  logic [3:0] retry_count;

  modport master (
    input  pll_locked, restart,
    output pll_rst, core_rst, ready, fault, lock_lost_stb, retry_count
  );

  modport slave (
    output pll_locked, restart,
    input  pll_rst, core_rst, ready, fault, lock_lost_stb, retry_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock over a programmable
// window and only then releases the core reset; handles lock loss, timeouts, retries and fault.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 74250,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_sequencer_if.master  bus
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic             lock_p0;
  logic             lock_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;
  logic             stb_nxt;
  logic             enter;

  // Stage p0/p1: two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= bus.pll_locked;
      lock_s  <= lock_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = bus.retry_count;
    stb_nxt   = 1'b0;
    if (bus.restart) begin
      state_nxt = S_RESET_PLL;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        S_RESET_PLL: if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          // Lock beats a timeout that falls due in the same cycle
          if (lock_s) begin
            state_nxt = S_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (bus.retry_count < RETRY_MAX) begin
              retry_nxt = bus.retry_count + 4'd1;
              state_nxt = S_RESET_PLL;
            end else begin
              state_nxt = S_FAULT;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s)                  state_nxt = S_WAIT_LOCK;
          else if (cnt == STABLE_LAST)  state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!lock_s) begin
            stb_nxt   = 1'b1;
            retry_nxt = 4'd0;
            state_nxt = S_RESET_PLL;
          end
        end
        S_FAULT: state_nxt = S_FAULT;
        default: state_nxt = S_RESET_PLL;
      endcase
    end

    enter = bus.restart || (state_nxt != state);
    if (enter)
      cnt_nxt = '0;
    else if (state == S_RUN || state == S_FAULT)
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + CNT_W'(1);
  end

  // Stage p2: state, counter and outputs decoded from the next state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state             <= S_RESET_PLL;
      cnt               <= '0;
      bus.pll_rst       <= 1'b1;
      bus.core_rst      <= 1'b1;
      bus.ready         <= 1'b0;
      bus.fault         <= 1'b0;
      bus.lock_lost_stb <= 1'b0;
      bus.retry_count   <= 4'd0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      bus.pll_rst       <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
      bus.core_rst      <= (state_nxt != S_RUN);
      bus.ready         <= (state_nxt == S_RUN);
      bus.fault         <= (state_nxt == S_FAULT);
      bus.lock_lost_stb <= stb_nxt;
      bus.retry_count   <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: hand-derived vector table for the directed scenarios,
// then randomized lock/restart traffic compared cycle by cycle with a behavioural model.
module tb_pll_lock_sequencer;

  localparam int RST_PULSE = 4;
  localparam int STABLE    = 8;
  localparam int TIMEOUT   = 32;
  localparam int MAXR      = 2;

  logic refclk;
  logic rst;
  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (RST_PULSE),
    .LOCK_STABLE_CYCLES (STABLE),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  // Packed view: {pll_rst, core_rst, ready, fault, lock_lost_stb, retry_count[3:0]}
  function automatic logic [8:0] pk(bit p, bit c, bit rd, bit f, bit s, int ret);
    return {p, c, rd, f, s, 4'(ret)};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.pll_rst, bus.core_rst, bus.ready, bus.fault, bus.lock_lost_stb, bus.retry_count};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: {pll_rst,core_rst,ready,fault,stb,retry} got %b expected %b at %0t",
               name, got, exp, $time);
    end
  endtask

  // Behavioural reference: phase plus elapsed cycles, lock seen through a 2-deep delay line
  typedef enum int {M_RESET, M_WAIT, M_STABLE, M_RUN, M_FAULT} mphase_t;
  mphase_t m_ph;
  int      m_t;
  int      m_retries;
  bit      m_stb;
  bit      m_pipe[$];

  task automatic model_reset();
    m_ph = M_RESET;
    m_t = 0;
    m_retries = 0;
    m_stb = 0;
    m_pipe = {1'b0, 1'b0};
  endtask

  task automatic model_step();
    bit lk;
    lk = m_pipe[0];
    void'(m_pipe.pop_front());
    m_pipe.push_back(bus.pll_locked);
    m_stb = 0;
    if (bus.restart) begin
      m_ph = M_RESET; m_t = 0; m_retries = 0;
    end else begin
      case (m_ph)
        M_RESET: begin
          m_t++;
          if (m_t == RST_PULSE) begin m_ph = M_WAIT; m_t = 0; end
        end
        M_WAIT: begin
          if (lk) begin
            m_ph = M_STABLE; m_t = 0;
          end else begin
            m_t++;
            if (m_t == TIMEOUT) begin
              m_t = 0;
              if (m_retries < MAXR) begin m_retries++; m_ph = M_RESET; end
              else m_ph = M_FAULT;
            end
          end
        end
        M_STABLE: begin
          if (!lk) begin
            m_ph = M_WAIT; m_t = 0;
          end else begin
            m_t++;
            if (m_t == STABLE) begin m_ph = M_RUN; m_t = 0; end
          end
        end
        M_RUN: begin
          if (!lk) begin m_stb = 1; m_retries = 0; m_ph = M_RESET; m_t = 0; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [8:0] model_out();
    return pk((m_ph == M_RESET) || (m_ph == M_FAULT), m_ph != M_RUN, m_ph == M_RUN,
              m_ph == M_FAULT, m_stb, m_retries);
  endfunction

  task automatic cyc();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    check("model", obs(), model_out());
  endtask

  // Asynchronous reset raised mid-low-phase; outputs must settle before any edge
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    bus.restart = 1'b0;
    #1 check("async_rst", obs(), pk(1, 1, 0, 0, 0, 0));
    @(negedge refclk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit         locked;
    bit         restart;
    int         n;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit l, bit r, int n, logic [8:0] e);
    vec_t v;
    v.locked = l; v.restart = r; v.n = n; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.restart = 1'b0;
    model_reset();

    // Reset release, first pulse, lock 10 cycles after pll_rst falls, 11-cycle release
    add(0,0,3, pk(1,1,0,0,0,0)); add(0,0,1, pk(0,1,0,0,0,0)); add(0,0,9, pk(0,1,0,0,0,0));
    add(1,0,10,pk(0,1,0,0,0,0)); add(1,0,1, pk(0,0,1,0,0,0)); add(1,0,5, pk(0,0,1,0,0,0));
    // Lock loss in RUN: strobe on the 3rd edge, 4-cycle pulse, normal re-release
    add(0,0,2, pk(0,0,1,0,0,0)); add(0,0,1, pk(1,1,0,0,1,0)); add(1,0,1, pk(1,1,0,0,0,0));
    add(1,0,2, pk(1,1,0,0,0,0)); add(1,0,1, pk(0,1,0,0,0,0)); add(1,0,8, pk(0,1,0,0,0,0));
    add(1,0,1, pk(0,0,1,0,0,0));
    // Restart in the same cycle lock_s falls in RUN: no strobe
    add(0,0,2, pk(0,0,1,0,0,0)); add(0,1,1, pk(1,1,0,0,0,0)); add(0,0,3, pk(1,1,0,0,0,0));
    add(0,0,1, pk(0,1,0,0,0,0));
    // One-cycle glitch after 5 STABLE cycles; release 11 cycles after the final rise
    add(1,0,6, pk(0,1,0,0,0,0)); add(0,0,1, pk(0,1,0,0,0,0)); add(1,0,2, pk(0,1,0,0,0,0));
    add(1,0,8, pk(0,1,0,0,0,0)); add(1,0,1, pk(0,0,1,0,0,0));
    // Lock held low: three pulses separated by 32-cycle waits, then sticky FAULT
    add(0,0,3, pk(1,1,0,0,1,0)); add(0,0,3, pk(1,1,0,0,0,0)); add(0,0,1, pk(0,1,0,0,0,0));
    add(0,0,31,pk(0,1,0,0,0,0)); add(0,0,1, pk(1,1,0,0,0,1)); add(0,0,4, pk(0,1,0,0,0,1));
    add(0,0,31,pk(0,1,0,0,0,1)); add(0,0,1, pk(1,1,0,0,0,2)); add(0,0,4, pk(0,1,0,0,0,2));
    add(0,0,31,pk(0,1,0,0,0,2)); add(0,0,1, pk(1,1,0,1,0,2)); add(1,0,10,pk(1,1,0,1,0,2));
    // Restart out of FAULT, fresh pulse, then one timeout to reach retry_count=1
    add(0,1,1, pk(1,1,0,0,0,0)); add(0,0,3, pk(1,1,0,0,0,0)); add(0,0,1, pk(0,1,0,0,0,0));
    add(0,0,31,pk(0,1,0,0,0,0)); add(0,0,1, pk(1,1,0,0,0,1)); add(0,0,4, pk(0,1,0,0,0,1));
    add(0,0,5, pk(0,1,0,0,0,1));

    @(negedge refclk);
    @(negedge refclk);
    check("reset_state", obs(), pk(1, 1, 0, 0, 0, 0));
    rst = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      bus.pll_locked = tbl[i].locked;
      bus.restart = tbl[i].restart;
      repeat (tbl[i].n) cyc();
      check($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end
    bus.restart = 1'b0;

    // Async reset mid-WAIT_LOCK with retry_count=1, then the sequence restarts from zero
    async_reset_pulse();
    repeat (3) cyc();
    check("post_rst_pulse", obs(), pk(1, 1, 0, 0, 0, 0));
    cyc();
    check("post_rst_wait", obs(), pk(0, 1, 0, 0, 0, 0));

    for (int seg = 0; seg < 160; seg++) begin
      bit lvl;
      int len;
      lvl = ($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
      for (int k = 0; k < len; k++) begin
        bus.pll_locked = lvl;
        bus.restart = ($urandom_range(0, 63) == 0);
        cyc();
      end
      if (seg == 80) async_reset_pulse();
    end
    bus.restart = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
